exec_decode_unit: RTL and testbench
===================================

EXEC_DECODE_UNIT -- requirements
Module: exec_decode_unit

Interface
REQ-001 Parameter DATA_W, default 8: ALU operand/result and extended-address width; all other fields are fixed width.
REQ-002 clk0  input  1  single clock; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; it is sampled only on the clk0 rising edge.
REQ-004 op  input  4  instruction opcode, decoded into the control outputs.
REQ-005 oper  input  3  ALU operation select.
REQ-006 a, b  input  DATA_W each  ALU operands.
REQ-007 addr  input  7  jump address field of the instruction.
REQ-008 jump, memtoreg, memwrite, regwrite, alusrc, branch  output  1 each  registered control signals.
REQ-009 result  output  DATA_W  registered ALU result.
REQ-010 iszero  output  1  registered flag; 1 when result is all zeros.
REQ-011 addrex  output  DATA_W  registered extended jump address.

Function
REQ-012 All outputs are registered, with 1-cycle latency: inputs sampled at edge N appear after edge N and hold until edge N+1.
REQ-013 Control decode of op (order: jump, memtoreg, memwrite, regwrite, alusrc, branch):
- 0000 R-type ALU: 0,0,0,1,0,0
- 0001 ALU-immediate: 0,0,0,1,1,0
- 0010 LOAD: 0,1,0,1,1,0
- 0011 STORE: 0,0,1,0,1,0
- 0100 BEQ: 0,0,0,0,0,1
- 0101 JUMP: 1,0,0,0,0,0
- 0110-1111: all zero (NOP)
REQ-014 ALU operations selected by oper:
- 000 ADD: a+b
- 001 SUB: a-b
- 010 AND
- 011 OR
- 100 XOR
- 101 NOR
- 110 SLL: a shifted left by b[2:0]
- 111 SRL: a logically shifted right by b[2:0]
REQ-015 Arithmetic is unsigned modulo 2^DATA_W; no carry or overflow output; ADD and SUB wrap silently.
REQ-016 iszero is computed from the same-cycle ALU value, so it always agrees with the registered result.
REQ-017 addrex is addr zero-extended to DATA_W, i.e. {0, addr}.
REQ-018 The control decode, the ALU and the address extension are mutually independent; any op/oper pairing is legal and produces no interlock.
REQ-019 The unit has no enable input: every non-reset edge loads new values.

Reset
REQ-020 While reset is high at a clk0 edge, all outputs take 0, except iszero which takes 1 to stay consistent with result=0; reset takes priority over all inputs.
REQ-021 If reset is asserted mid-stream, the next edge clears the outputs regardless of inputs; the first non-reset edge loads the current inputs normally.
REQ-022 Output values before the first clk0 edge are undefined; the bench holds reset for at least one edge.

Structure
REQ-023 A shared package holds the opcode constants (OP_RTYPE, OP_ALUI, OP_LOAD, OP_STORE, OP_BEQ, OP_JUMP) and the ALU-op constants (ALU_ADD through ALU_SRL).
REQ-024 One sub-module, alu_core, is a purely combinational DATA_W-bit ALU producing the result value and the zero flag; decode, extension and output registers live in the top.

Verification
REQ-025 Reset: reset=1, op=0001, a=5, b=3 for one edge -> all controls 0, result=0, iszero=1, addrex=0.
REQ-026 ADD wrap: op=0000, oper=000, a=8'hFF, b=8'h01 -> after one edge result=8'h00, iszero=1, regwrite=1, alusrc=0.
REQ-027 SUB, BEQ taken: op=0100, oper=001, a=8'h2A, b=8'h2A -> result=0, iszero=1, branch=1; then a=8'h2B -> result=1, iszero=0.
REQ-028 JUMP: op=0101, addr=7'h7F -> jump=1, addrex=8'h7F, all other controls 0.
REQ-029 Shift and logic sweep: a=8'h81, b=8'h03 with oper 110/111/010/011/100/101 -> 8'h08, 8'h10, 8'h01, 8'h83, 8'h82, 8'h7C.
REQ-030 Decode sweep with mid-run reset: all 16 opcodes applied on consecutive edges, reset pulsed at op=0011 -> REQ-013 table verified, the pulsed edge yields all-zero controls, and op=0010 (LOAD) gives memtoreg=1, regwrite=1, alusrc=1.

Source files
------------

// File: rtl/exec_decode_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : exec_decode_unit_pkg
// Brief  : Opcode and ALU-operation encodings shared by the decode unit.
// Rev    : 1.0 - initial release
// ============================================================================
package exec_decode_unit_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_JUMP  = 4'b0101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Control bundle order: jump, memtoreg, memwrite, regwrite, alusrc, branch
    typedef struct packed {
        logic jump;
        logic memtoreg;
        logic memwrite;
        logic regwrite;
        logic alusrc;
        logic branch;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/exec_decode_unit_alu_core.sv
`default_nettype none
// ============================================================================
// Module : alu_core
// Brief  : Combinational DATA_W-bit ALU with zero flag.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_core
    import exec_decode_unit_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        i_oper,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    logic [DATA_W-1:0] w_result;
    logic [2:0]        w_shamt;

    assign w_shamt = i_b[2:0];

    always_comb begin
        w_result = '0;
        case (i_oper)
            ALU_ADD: w_result = i_a + i_b;
            ALU_SUB: w_result = i_a - i_b;
            ALU_AND: w_result = i_a & i_b;
            ALU_OR:  w_result = i_a | i_b;
            ALU_XOR: w_result = i_a ^ i_b;
            ALU_NOR: w_result = ~(i_a | i_b);
            ALU_SLL: w_result = i_a << w_shamt;
            ALU_SRL: w_result = i_a >> w_shamt;
            default: w_result = '0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == '0);

endmodule
`default_nettype wire

// File: rtl/exec_decode_unit.sv
`default_nettype none
// ============================================================================
// Module : exec_decode_unit
// Brief  : Registered control decode, ALU result/zero flag and jump-address extension.
// Rev    : 1.0 - initial release
// ============================================================================
module exec_decode_unit
    import exec_decode_unit_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk0,
    input  logic              reset,
    input  logic [3:0]        op,
    input  logic [2:0]        oper,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [6:0]        addr,
    output logic              jump,
    output logic              memtoreg,
    output logic              memwrite,
    output logic              regwrite,
    output logic              alusrc,
    output logic              branch,
    output logic [DATA_W-1:0] result,
    output logic              iszero,
    output logic [DATA_W-1:0] addrex
);

    ctrl_t             w_ctrl;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_zero;
    logic [DATA_W-1:0] w_addrex;

    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_result;
    logic              r_iszero;
    logic [DATA_W-1:0] r_addrex;

    always_comb begin
        w_ctrl = '0;
        case (op)
            OP_RTYPE: w_ctrl = '{jump: 1'b0, memtoreg: 1'b0, memwrite: 1'b0,
                                 regwrite: 1'b1, alusrc: 1'b0, branch: 1'b0};
            OP_ALUI:  w_ctrl = '{jump: 1'b0, memtoreg: 1'b0, memwrite: 1'b0,
                                 regwrite: 1'b1, alusrc: 1'b1, branch: 1'b0};
            OP_LOAD:  w_ctrl = '{jump: 1'b0, memtoreg: 1'b1, memwrite: 1'b0,
                                 regwrite: 1'b1, alusrc: 1'b1, branch: 1'b0};
            OP_STORE: w_ctrl = '{jump: 1'b0, memtoreg: 1'b0, memwrite: 1'b1,
                                 regwrite: 1'b0, alusrc: 1'b1, branch: 1'b0};
            OP_BEQ:   w_ctrl = '{jump: 1'b0, memtoreg: 1'b0, memwrite: 1'b0,
                                 regwrite: 1'b0, alusrc: 1'b0, branch: 1'b1};
            OP_JUMP:  w_ctrl = '{jump: 1'b1, memtoreg: 1'b0, memwrite: 1'b0,
                                 regwrite: 1'b0, alusrc: 1'b0, branch: 1'b0};
            default:  w_ctrl = '0;
        endcase
    end

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .i_oper   (oper),
        .i_a      (a),
        .i_b      (b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    assign w_addrex = DATA_W'(addr);

    // iszero resets high so it agrees with the cleared result
    always_ff @(posedge clk0) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_result <= '0;
            r_iszero <= 1'b1;
            r_addrex <= '0;
        end else begin
            r_ctrl   <= w_ctrl;
            r_result <= w_alu_result;
            r_iszero <= w_alu_zero;
            r_addrex <= w_addrex;
        end
    end

    assign jump     = r_ctrl.jump;
    assign memtoreg = r_ctrl.memtoreg;
    assign memwrite = r_ctrl.memwrite;
    assign regwrite = r_ctrl.regwrite;
    assign alusrc   = r_ctrl.alusrc;
    assign branch   = r_ctrl.branch;
    assign result   = r_result;
    assign iszero   = r_iszero;
    assign addrex   = r_addrex;

endmodule
`default_nettype wire

// File: tb/tb_exec_decode_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_exec_decode_unit
// Brief  : Directed self-checking bench for exec_decode_unit.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_exec_decode_unit;

    logic       clk0 = 1'b0;
    logic       reset;
    logic [3:0] op;
    logic [2:0] oper;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] addr;
    logic       jump, memtoreg, memwrite, regwrite, alusrc, branch;
    logic [7:0] result;
    logic       iszero;
    logic [7:0] addrex;

    int checks   = 0;
    int failures = 0;

    always #5 clk0 = ~clk0;

    exec_decode_unit #(
        .DATA_W (8)
    ) dut (
        .clk0     (clk0),
        .reset    (reset),
        .op       (op),
        .oper     (oper),
        .a        (a),
        .b        (b),
        .addr     (addr),
        .jump     (jump),
        .memtoreg (memtoreg),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .alusrc   (alusrc),
        .branch   (branch),
        .result   (result),
        .iszero   (iszero),
        .addrex   (addrex)
    );

    logic [5:0] w_ctrl_obs;
    assign w_ctrl_obs = {jump, memtoreg, memwrite, regwrite, alusrc, branch};

    function automatic logic [5:0] ctrl_ref(input logic [3:0] opc);
        case (opc)
            4'd0:    return 6'b000100;
            4'd1:    return 6'b000110;
            4'd2:    return 6'b010110;
            4'd3:    return 6'b001010;
            4'd4:    return 6'b000001;
            4'd5:    return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 4'b0001; oper = 3'b000; a = 8'd5; b = 8'd3; addr = 7'h55;
        step();
        check("rst_ctrl",   32'(w_ctrl_obs), 32'h0);
        check("rst_result", 32'(result),     32'h0);
        check("rst_iszero", 32'(iszero),     32'h1);
        check("rst_addrex", 32'(addrex),     32'h0);

        reset = 1'b0; op = 4'b0000; oper = 3'b000; a = 8'hFF; b = 8'h01; addr = 7'h00;
        step();
        check("add_wrap_result", 32'(result),     32'h00);
        check("add_wrap_iszero", 32'(iszero),     32'h1);
        check("add_wrap_ctrl",   32'(w_ctrl_obs), 32'b000100);

        op = 4'b0100; oper = 3'b001; a = 8'h2A; b = 8'h2A;
        step();
        check("beq_eq_result", 32'(result),     32'h00);
        check("beq_eq_iszero", 32'(iszero),     32'h1);
        check("beq_ctrl",      32'(w_ctrl_obs), 32'b000001);
        a = 8'h2B;
        step();
        check("beq_ne_result", 32'(result), 32'h01);
        check("beq_ne_iszero", 32'(iszero), 32'h0);

        op = 4'b0101; addr = 7'h7F;
        step();
        check("jump_ctrl",   32'(w_ctrl_obs), 32'b100000);
        check("jump_addrex", 32'(addrex),     32'h7F);

        a = 8'h81; b = 8'h03;
        oper = 3'b110; step(); check("sll", 32'(result), 32'h08);
        check("sll_iszero", 32'(iszero), 32'h0);
        oper = 3'b111; step(); check("srl", 32'(result), 32'h10);
        oper = 3'b010; step(); check("and", 32'(result), 32'h01);
        oper = 3'b011; step(); check("or",  32'(result), 32'h83);
        oper = 3'b100; step(); check("xor", 32'(result), 32'h82);
        oper = 3'b101; step(); check("nor", 32'(result), 32'h7C);

        oper = 3'b000; a = 8'h01; b = 8'h02; addr = 7'h2A;
        for (int i = 0; i < 16; i++) begin
            op    = 4'(i);
            reset = (i == 3);
            step();
            if (i == 3) begin
                check("sweep_rst_ctrl",   32'(w_ctrl_obs), 32'h0);
                check("sweep_rst_result", 32'(result),     32'h0);
                check("sweep_rst_iszero", 32'(iszero),     32'h1);
                check("sweep_rst_addrex", 32'(addrex),     32'h0);
            end else begin
                check($sformatf("sweep_ctrl_op%0d", i), 32'(w_ctrl_obs), 32'(ctrl_ref(4'(i))));
                check($sformatf("sweep_res_op%0d", i),  32'(result),     32'h03);
                check($sformatf("sweep_addr_op%0d", i), 32'(addrex),     32'h2A);
            end
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
